// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: access sizes, FSM states,
// the latched request record and the MMIO register offsets.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        WRITE,
        RESP
    } state_e;

    localparam logic [3:0] LED_OFF = 4'h0;
    localparam logic [3:0] SW_OFF  = 4'h8;

    // Only the byte lane survives acceptance; the word index lives in mem_address.
    typedef struct packed {
        logic        write;
        size_e       size;
        logic        sign;
        logic [2:0]  off;
        logic [63:0] wdata;
    } req_t;

    function automatic logic is_aligned(input logic [2:0] off, input size_e size);
        case (size)
            SZ_B:    return 1'b1;
            SZ_H:    return off[0] == 1'b0;
            SZ_W:    return off[1:0] == 2'b00;
            default: return off == 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response bus between the MEM stage (master) and the load/store unit (slave).
interface load_store_unit_if;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        stall;
    logic        misaligned;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, stall, misaligned
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, stall, misaligned
    );
endinterface

// File: rtl/lane_align.sv
// Combinational byte-lane steering: extracts/extends a load lane from a memory
// word, and merges store bytes into an old word using little-endian byte enables.
module lane_align
    import lsu_pkg::*;
(
    input  size_e       size,
    input  logic        sign,
    input  logic [2:0]  offset,
    input  logic [63:0] rd_word,
    input  logic [63:0] wdata,
    output logic [63:0] load_data,
    output logic [63:0] merged
);

    logic [63:0] shifted;
    logic [63:0] placed;
    logic [7:0]  be;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path infers a latch.
        shifted   = rd_word >> {offset, 3'b000};
        placed    = wdata << {offset, 3'b000};
        load_data = shifted;
        merged    = rd_word;
        be        = 8'h00;
        case (size)
            SZ_B: begin
                load_data = {{56{sign & shifted[7]}}, shifted[7:0]};
                be        = 8'h01;
            end
            SZ_H: begin
                load_data = {{48{sign & shifted[15]}}, shifted[15:0]};
                be        = 8'h03;
            end
            SZ_W: begin
                load_data = {{32{sign & shifted[31]}}, shifted[31:0]};
                be        = 8'h0f;
            end
            default: begin
                load_data = shifted;
                be        = 8'hff;
            end
        endcase
        be = be << offset;
        for (int i = 0; i < 8; i++) begin
            merged[i*8 +: 8] = be[i] ? placed[i*8 +: 8] : rd_word[i*8 +: 8];
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: request latch, access FSM, read-modify-write for
// sub-doubleword stores, and the LED/switch MMIO window.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int          MEM_LAT   = 1,
    parameter logic [63:0] MMIO_BASE = 64'h0000_0000_0000_1000,
    parameter int          LED_W     = 27,
    parameter int          SW_W      = 18
) (
    input  logic              clock,
    input  logic              reset,
    load_store_unit_if.slave  bus,
    output logic [63:0]       mem_address,
    output logic [63:0]       mem_write_data,
    output logic              MemWrite,
    output logic              MemRead,
    input  logic [63:0]       mem_read_data,
    input  logic [SW_W-1:0]   switches,
    output logic [LED_W-1:0]  leds
);

    localparam logic [1:0] LAT_LAST = 2'(MEM_LAT - 1);

    state_e            state, state_n;
    req_t              req_q;
    logic [1:0]        lat_cnt;
    logic [63:0]       rdata_q;
    logic              misal_q;
    logic [LED_W-1:0]  leds_q;
    logic              accept, in_aligned, in_mmio, rd_last;
    size_e             in_size;
    logic [63:0]       load_data, merged;

    assign in_size    = size_e'(bus.req_size);
    assign accept     = (state == IDLE) && bus.req_valid;
    assign in_aligned = is_aligned(bus.req_addr[2:0], in_size);
    assign in_mmio    = bus.req_addr[63:4] == MMIO_BASE[63:4];
    assign rd_last    = lat_cnt == LAT_LAST;

    lane_align u_lane_align (
        .size      (req_q.size),
        .sign      (req_q.sign),
        .offset    (req_q.off),
        .rd_word   (mem_read_data),
        .wdata     (req_q.wdata),
        .load_data (load_data),
        .merged    (merged)
    );

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (accept) begin
                if (!in_aligned || in_mmio)            state_n = RESP;
                else if (bus.req_write && in_size == SZ_D) state_n = WRITE;
                else                                   state_n = RD_WAIT;
            end
            RD_WAIT: if (rd_last) state_n = req_q.write ? WRITE : RESP;
            WRITE:   state_n = RESP;
            default: state_n = IDLE;
        endcase
    end

    // NOTE: all state updates below use non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            req_q          <= '0;
            lat_cnt        <= '0;
            rdata_q        <= '0;
            misal_q        <= 1'b0;
            leds_q         <= '0;
            MemRead        <= 1'b0;
            MemWrite       <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= '0;
        end else begin
            state    <= state_n;
            MemRead  <= state_n == RD_WAIT;
            MemWrite <= state_n == WRITE;
            if (accept) begin
                req_q   <= '{write: bus.req_write, size: in_size, sign: bus.req_signed,
                            off: bus.req_addr[2:0], wdata: bus.req_wdata};
                misal_q <= !in_aligned;
                rdata_q <= '0;
                lat_cnt <= '0;
                if (in_aligned && in_mmio) begin
                    if (bus.req_write && bus.req_addr[3:0] == LED_OFF)
                        leds_q <= bus.req_wdata[LED_W-1:0];
                    if (!bus.req_write && bus.req_addr[3:0] == SW_OFF)
                        rdata_q <= 64'(switches);
                end else if (in_aligned) begin
                    mem_address <= {3'b000, bus.req_addr[63:3]};
                    if (bus.req_write && in_size == SZ_D)
                        mem_write_data <= bus.req_wdata;
                end
            end
            if (state == RD_WAIT) begin
                lat_cnt <= lat_cnt + 2'd1;
                if (rd_last) begin
                    if (req_q.write) mem_write_data <= merged;
                    else             rdata_q        <= load_data;
                end
            end
        end
    end

    assign bus.req_ready  = state == IDLE;
    assign bus.resp_valid = state == RESP;
    assign bus.resp_rdata = (state == RESP) ? rdata_q : '0;
    assign bus.misaligned = (state == RESP) && misal_q;
    assign bus.stall      = (bus.req_valid && state != IDLE) || state == RD_WAIT || state == WRITE;
    assign leds           = leds_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: byte-level reference memory model, per-cycle
// output compare against expected-response/write queues, plus literal pin checks.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int          MEM_LAT   = 1;
    localparam logic [63:0] MMIO_BASE = 64'h0000_0000_0000_1000;
    localparam int          LED_W     = 27;
    localparam int          SW_W      = 18;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    load_store_unit_if bus();
    logic [63:0]      mem_address, mem_write_data, mem_read_data;
    logic             MemWrite, MemRead;
    logic [SW_W-1:0]  switches = 18'h2AAAA;
    logic [LED_W-1:0] leds;

    load_store_unit #(.MEM_LAT(MEM_LAT), .MMIO_BASE(MMIO_BASE), .LED_W(LED_W), .SW_W(SW_W)) dut (
        .clock          (clock),
        .reset          (reset),
        .bus            (bus),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .MemWrite       (MemWrite),
        .MemRead        (MemRead),
        .mem_read_data  (mem_read_data),
        .switches       (switches),
        .leds           (leds)
    );

    // Environment memory: written by the DUT or by bench preloads.
    logic [63:0] env_mem [16];
    logic        poke_en = 1'b0;
    logic [3:0]  poke_idx = '0;
    logic [63:0] poke_data = '0;
    always @(posedge clock) begin
        if (MemWrite) env_mem[mem_address[3:0]] <= mem_write_data;
        if (poke_en)  env_mem[poke_idx] <= poke_data;
    end
    assign mem_read_data = MemRead ? env_mem[mem_address[3:0]] : 64'hDEAD_DEAD_DEAD_DEAD;

    typedef struct { logic [63:0] rdata; logic misal; } resp_t;
    typedef struct { logic [63:0] addr; logic [63:0] data; } wr_t;

    logic [63:0]      ref_mem [16];
    resp_t            exp_resp [$];
    wr_t              exp_wr [$];
    logic [63:0]      exp_rd_addr = '0;
    logic [LED_W-1:0] exp_leds = '0;
    int               rd_cycles = 0;
    bit               in_reset = 1'b1;
    int               n_vec = 0;
    int               n_err = 0;
    resp_t            r_c;
    wr_t              w_c;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: got event missing expected event present", name);
    endtask

    function automatic logic [63:0] model_load(input logic [63:0] word, input int off,
                                               input int nb, input logic sg);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = word[8*(off+i) +: 8];
        if (sg && v[8*nb-1]) for (int i = nb; i < 8; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    // Per-cycle compare against the model's queues.
    always @(negedge clock) begin
        if (!in_reset) begin
            check("strobe_overlap", 64'(MemRead & MemWrite), 64'd0);
            check("leds", 64'(leds), 64'(exp_leds));
            if (MemRead) begin
                rd_cycles++;
                check("rd_addr", mem_address, exp_rd_addr);
                check("stall_busy", 64'(bus.stall), 64'd1);
            end
            if (MemWrite) begin
                check("ready_busy", 64'(bus.req_ready), 64'd0);
                if (exp_wr.size() == 0) fail("unexpected_memwrite");
                else begin
                    w_c = exp_wr.pop_front();
                    check("wr_addr", mem_address, w_c.addr);
                    check("wr_data", mem_write_data, w_c.data);
                end
            end
            if (bus.resp_valid) begin
                if (exp_resp.size() == 0) fail("unexpected_resp");
                else begin
                    r_c = exp_resp.pop_front();
                    check("resp_rdata", bus.resp_rdata, r_c.rdata);
                    check("misaligned", 64'(bus.misaligned), 64'(r_c.misal));
                end
            end else begin
                check("misaligned_idle", 64'(bus.misaligned), 64'd0);
            end
        end
    end

    task automatic poke(input logic [3:0] idx, input logic [63:0] data);
        @(negedge clock);
        poke_en = 1'b1; poke_idx = idx; poke_data = data;
        @(posedge clock);
        #1 poke_en = 1'b0;
        ref_mem[idx] = data;
    endtask

    task automatic accept_req(input logic wr, input logic [1:0] sz, input logic sg,
                              input logic [63:0] addr, input logic [63:0] wd);
        bit ready_seen;
        @(negedge clock);
        bus.req_valid = 1'b1; bus.req_write = wr; bus.req_size = sz;
        bus.req_signed = sg; bus.req_addr = addr; bus.req_wdata = wd;
        ready_seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (bus.req_ready) begin ready_seen = 1'b1; break; end
            @(negedge clock);
        end
        if (!ready_seen) fail("req_ready_timeout");
        @(posedge clock);
    endtask

    task automatic do_req(input string name, input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [63:0] addr, input logic [63:0] wd, output logic [63:0] got);
        int nb, off, exp_lat, exp_rd, lat;
        bit aligned, mmio, seen;
        logic [63:0] word;
        resp_t r;
        nb = 1 << sz;
        off = int'(addr[2:0]);
        aligned = (addr % 64'(nb)) == 0;
        mmio = addr[63:4] == MMIO_BASE[63:4];
        accept_req(wr, sz, sg, addr, wd);
        rd_cycles = 0;
        exp_rd = 0;
        r.rdata = '0;
        r.misal = 1'b0;
        if (!aligned) begin
            r.misal = 1'b1;
            exp_lat = 1;
        end else if (mmio) begin
            if (!wr && addr[3:0] == 4'h8) r.rdata = 64'(switches);
            if (wr && addr[3:0] == 4'h0) exp_leds = wd[LED_W-1:0];
            exp_lat = 1;
        end else begin
            word = ref_mem[addr[6:3]];
            exp_rd_addr = addr >> 3;
            if (!wr) begin
                r.rdata = model_load(word, off, nb, sg);
                exp_rd = MEM_LAT;
                exp_lat = MEM_LAT + 1;
            end else begin
                for (int i = 0; i < nb; i++) word[8*(off+i) +: 8] = wd[8*i +: 8];
                ref_mem[addr[6:3]] = word;
                exp_wr.push_back('{addr: addr >> 3, data: word});
                exp_rd = (nb == 8) ? 0 : MEM_LAT;
                exp_lat = (nb == 8) ? 2 : MEM_LAT + 2;
            end
        end
        exp_resp.push_back(r);
        // Scramble the request inputs: the DUT must work from its latched copy.
        #1;
        bus.req_valid = 1'b0; bus.req_addr = ~addr; bus.req_wdata = ~wd;
        bus.req_size = ~sz; bus.req_write = ~wr; bus.req_signed = ~sg;
        seen = 1'b0;
        lat = 0;
        got = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            if (bus.resp_valid) begin seen = 1'b1; lat = k; got = bus.resp_rdata; break; end
        end
        if (!seen) fail({name, "_resp_timeout"});
        else check({name, "_latency"}, 64'(lat), 64'(exp_lat));
        check({name, "_read_cycles"}, 64'(rd_cycles), 64'(exp_rd));
        check({name, "_writes_pending"}, 64'(exp_wr.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"},  64'(bus.req_ready), 64'd1);
        check({tag, "_resp_valid"}, 64'(bus.resp_valid), 64'd0);
        check({tag, "_resp_rdata"}, bus.resp_rdata, 64'd0);
        check({tag, "_stall"},      64'(bus.stall), 64'd0);
        check({tag, "_misaligned"}, 64'(bus.misaligned), 64'd0);
        check({tag, "_MemRead"},    64'(MemRead), 64'd0);
        check({tag, "_MemWrite"},   64'(MemWrite), 64'd0);
        check({tag, "_mem_address"}, mem_address, 64'd0);
        check({tag, "_mem_wdata"},  mem_write_data, 64'd0);
        check({tag, "_leds"},       64'(leds), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "simulation watchdog expired");
    end

    initial begin
        logic [63:0] got;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
        bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        repeat (2) @(negedge clock);
        check_reset_outputs("por");
        reset = 1'b0;
        #1 in_reset = 1'b0;

        poke(4'd3, 64'h1122_3344_5566_7788);
        poke(4'd2, 64'h0123_4567_89AB_CDEF);
        poke(4'd5, 64'hFFEE_DDCC_BBAA_9988);

        // Loads: doubleword, signed/unsigned bytes, half and word lanes.
        do_req("ldurd", 1'b0, SZ_D, 1'b0, 64'h18, '0, got);
        check("ldurd_lit", got, 64'h1122_3344_5566_7788);
        do_req("ldursb", 1'b0, SZ_B, 1'b1, 64'h1F, '0, got);
        check("ldursb_lit", got, 64'h0000_0000_0000_0011);
        poke(4'd3, 64'h8011_2233_4455_6677);
        do_req("ldursb_neg", 1'b0, SZ_B, 1'b1, 64'h1F, '0, got);
        check("ldursb_neg_lit", got, 64'hFFFF_FFFF_FFFF_FF80);
        do_req("ldurb", 1'b0, SZ_B, 1'b0, 64'h1F, '0, got);
        check("ldurb_lit", got, 64'h0000_0000_0000_0080);
        poke(4'd3, 64'h1122_3344_5566_7788);
        do_req("ldursh", 1'b0, SZ_H, 1'b1, 64'h2C, '0, got);
        check("ldursh_lit", got, 64'hFFFF_FFFF_FFFF_DDCC);
        do_req("ldurw", 1'b0, SZ_W, 1'b0, 64'h28, '0, got);
        check("ldurw_lit", got, 64'h0000_0000_BBAA_9988);

        // Stores: read-modify-write for sub-doubleword, direct write for doubleword.
        do_req("sturh", 1'b1, SZ_H, 1'b0, 64'h1A, 64'h0000_0000_0000_BEEF, got);
        do_req("ldurd_after_sturh", 1'b0, SZ_D, 1'b0, 64'h18, '0, got);
        check("sturh_lit", got, 64'h1122_3344_BEEF_7788);
        do_req("sturb", 1'b1, SZ_B, 1'b0, 64'h2F, 64'hFFFF_FFFF_FFFF_FF5A, got);
        do_req("ldurd_w5", 1'b0, SZ_D, 1'b0, 64'h28, '0, got);
        check("sturb_lit", got, 64'h5AEE_DDCC_BBAA_9988);
        do_req("sturw", 1'b1, SZ_W, 1'b0, 64'h14, 64'h0000_0000_DEAD_BEEF, got);
        do_req("sturd", 1'b1, SZ_D, 1'b0, 64'h30, 64'hA5A5_0F0F_3C3C_9696, got);
        do_req("ldurd_w6", 1'b0, SZ_D, 1'b0, 64'h30, '0, got);
        check("sturd_lit", got, 64'hA5A5_0F0F_3C3C_9696);

        // MMIO window.
        do_req("led_store", 1'b1, SZ_D, 1'b0, MMIO_BASE, 64'h5A5, got);
        check("led_lit", 64'(leds), 64'h5A5);
        do_req("sw_load", 1'b0, SZ_D, 1'b0, MMIO_BASE + 64'h8, '0, got);
        check("sw_lit", got, 64'h2AAAA);
        do_req("mmio_other_load", 1'b0, SZ_W, 1'b0, MMIO_BASE + 64'h4, '0, got);
        check("mmio_other_lit", got, 64'd0);
        do_req("mmio_other_store", 1'b1, SZ_W, 1'b0, MMIO_BASE + 64'h4, 64'h7, got);
        check("led_kept_lit", 64'(leds), 64'h5A5);
        do_req("led_wide", 1'b1, SZ_B, 1'b0, MMIO_BASE, 64'hFFFF_FFFF, got);
        check("led_wide_lit", 64'(leds), 64'h7FF_FFFF);

        // Misaligned requests: no strobes, zero data.
        do_req("mis_ldw", 1'b0, SZ_W, 1'b0, 64'h06, '0, got);
        check("mis_ldw_lit", got, 64'd0);
        do_req("mis_sth", 1'b1, SZ_H, 1'b0, 64'h21, 64'h1234, got);
        do_req("mis_ldd", 1'b0, SZ_D, 1'b0, 64'h1C, '0, got);

        // Reset in the middle of a half-store read phase: the write must never appear.
        accept_req(1'b1, SZ_H, 1'b0, 64'h12, 64'hCAFE);
        exp_rd_addr = 64'h2;
        #1 bus.req_valid = 1'b0;
        @(negedge clock);
        check("rst_mid_memread", 64'(MemRead), 64'd1);
        in_reset = 1'b1;
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check_reset_outputs("mid_rst");
        reset = 1'b0;
        exp_leds = '0;
        #1 in_reset = 1'b0;
        repeat (3) @(negedge clock);
        do_req("ldurd_after_rst", 1'b0, SZ_D, 1'b0, 64'h10, '0, got);
        check("rst_abandon_lit", got, 64'hDEAD_BEEF_89AB_CDEF);
        do_req("ldurh_after_rst", 1'b0, SZ_H, 1'b0, 64'h12, '0, got);
        check("rst_half_lit", got, 64'h0000_0000_0000_89AB);

        repeat (2) @(negedge clock);
        check("resp_queue_empty", 64'(exp_resp.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
